// File: rtl/fpu_muldiv_seq_pkg.sv
// Shared types, flag indices and special-value packet helper for the Sol-1
// iterative FP multiply/divide unit.
package pa_fpu;

  typedef enum logic {
    op_mul_seq = 1'b0,
    op_div_seq = 1'b1
  } e_muldiv_op;

  typedef enum logic [2:0] {
    md_idle_st,
    md_unpack_st,
    md_iter_st,
    md_norm_st,
    md_pack_st
  } e_muldiv_state;

  localparam int FLG_W         = 5;
  localparam int FLG_INVALID   = 4;
  localparam int FLG_DIV_ZERO  = 3;
  localparam int FLG_OVERFLOW  = 2;
  localparam int FLG_UNDERFLOW = 1;
  localparam int FLG_ZERO      = 0;

  // Builds Inf (nan=0, signed) or quiet NaN (nan=1, sign forced 0) for any
  // packet geometry up to 64 bits; callers size-cast to their width.
  function automatic logic [63:0] special_pkt(input int exp_w, input int man_w,
                                              input logic sign, input logic nan);
    logic [63:0] pkt;
    pkt = ((64'd1 << exp_w) - 64'd1) << man_w;
    if (nan) pkt = pkt | (64'd1 << (man_w - 1));
    else     pkt = pkt | ({63'd0, sign} << (exp_w + man_w));
    return pkt;
  endfunction

endpackage

// File: rtl/fpu_muldiv_seq_if.sv
// Start/done request interface between the FPU bus logic (master) and the
// multiply/divide core (slave).
interface fpu_muldiv_seq_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
);
  import pa_fpu::*;

  localparam int W = 1 + EXP_W + MAN_W;

  logic             start;
  e_muldiv_op       op;
  logic [W-1:0]     operand_a;
  logic [W-1:0]     operand_b;
  logic             busy;
  logic             done;
  logic [W-1:0]     result;
  logic [FLG_W-1:0] flags;

  modport master (
    output start, op, operand_a, operand_b,
    input  busy, done, result, flags
  );

  modport slave (
    input  start, op, operand_a, operand_b,
    output busy, done, result, flags
  );

endinterface

// File: rtl/fpu_sig_iter.sv
// Significand engine: shift-add multiply (P steps) or restoring divide
// (P+1 steps), one step per enabled cycle.
module fpu_sig_iter
  import pa_fpu::*;
#(
  parameter int P = 24
) (
  input  logic         clk,
  input  logic         arst,
  input  logic         load,
  input  logic         step,
  input  e_muldiv_op   mode,
  input  logic [P-1:0] sig_a,
  input  logic [P-1:0] sig_b,
  output logic         last_step,
  output logic [2*P-1:0] prod,
  output logic [P:0]   quo
);

  localparam int CW = $clog2(P + 2);

  logic [2*P:0] acc;
  logic [P-1:0] mcand;
  logic [P:0]   quo_q;
  logic [CW-1:0] cnt;
  e_muldiv_op   mode_q;

  logic [P:0] add_sum;
  logic [P:0] rem;
  logic [P:0] rem_diff;
  logic       rem_ge;
  logic       unused_acc_top;

  always_comb begin
    add_sum  = {1'b0, acc[2*P-1:P]} + (acc[0] ? {1'b0, mcand} : '0);
    rem      = acc[P:0];
    rem_ge   = (rem >= {1'b0, mcand});
    rem_diff = rem_ge ? (rem - {1'b0, mcand}) : rem;
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst)                    cnt <= '0;
    else if (load)               cnt <= (mode == op_div_seq) ? CW'(P + 1) : CW'(P);
    else if (step && cnt != '0)  cnt <= cnt - 1'b1;
  end

  // NOTE: datapath registers carry no reset; the FSM never consumes them
  // before a load, so a reset would only add fan-out on arst.
  always_ff @(posedge clk) begin
    if (load) begin
      mode_q <= mode;
      mcand  <= (mode == op_div_seq) ? sig_b : sig_a;
      acc    <= {{(P+1){1'b0}}, (mode == op_div_seq) ? sig_a : sig_b};
      quo_q  <= '0;
    end else if (step && cnt != '0) begin
      if (mode_q == op_mul_seq) begin
        acc <= {1'b0, add_sum, acc[P-1:1]};
      end else begin
        acc   <= {{P{1'b0}}, rem_diff[P-1:0], 1'b0};
        quo_q <= {quo_q[P-1:0], rem_ge};
      end
    end
  end

  assign last_step      = (cnt == CW'(1));
  assign prod           = acc[2*P-1:0];
  assign quo            = quo_q;
  assign unused_acc_top = acc[2*P];

endmodule

// File: rtl/fpu_muldiv_seq.sv
// Iterative FP multiply/divide: FSM, unpack, exponent path, normalisation,
// exception priority and packing around the fpu_sig_iter engine.
module fpu_muldiv_seq
  import pa_fpu::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input logic            clk,
  input logic            arst,
  fpu_muldiv_seq_if.slave bus
);

  localparam int P    = MAN_W + 1;
  localparam int W    = 1 + EXP_W + MAN_W;
  localparam int BIAS = (1 << (EXP_W - 1)) - 1;
  localparam int EW   = EXP_W + 2;

  localparam logic signed [EW-1:0] BIAS_E   = EW'(BIAS);
  localparam logic signed [EW-1:0] EXP_ALL1 = EW'((1 << EXP_W) - 1);
  localparam logic signed [EW-1:0] EXP_ONE  = EW'(1);
  localparam logic signed [EW-1:0] EXP_ZERO = '0;

  e_muldiv_state state, state_n;
  logic eng_load, eng_step, last_step;
  logic [P-1:0]   sig_a, sig_b;
  logic [2*P-1:0] prod;
  logic [P:0]     quo;
  logic           unused_prod;

  e_muldiv_op       op_q;
  logic             sa_q, sb_q, sign_q;
  logic [EXP_W-1:0] ea_q, eb_q;
  logic             a_zero_q, b_zero_q, any_special_q;
  logic signed [EW-1:0] ea_s, eb_s, exp_q, exp_n_q;
  logic [MAN_W-1:0] frac_q;

  logic             done_q;
  logic [W-1:0]     result_q, result_n;
  logic [FLG_W-1:0] flags_q, flags_n;

  // Flushed denormals get a zero hidden bit; the zero path overrides them anyway.
  assign sig_a = {|bus.operand_a[W-2:MAN_W], bus.operand_a[MAN_W-1:0]};
  assign sig_b = {|bus.operand_b[W-2:MAN_W], bus.operand_b[MAN_W-1:0]};

  fpu_sig_iter #(.P(P)) u_iter (
    .clk       (clk),
    .arst      (arst),
    .load      (eng_load),
    .step      (eng_step),
    .mode      (bus.op),
    .sig_a     (sig_a),
    .sig_b     (sig_b),
    .last_step (last_step),
    .prod      (prod),
    .quo       (quo)
  );

  always_ff @(posedge clk or posedge arst) begin
    if (arst) state <= md_idle_st;
    else      state <= state_n;
  end

  // NOTE: combinational blocks use blocking '=' and assign every output a
  // default first, so no path can leave a latch behind.
  always_comb begin
    state_n  = state;
    eng_load = 1'b0;
    eng_step = 1'b0;
    unique case (state)
      md_idle_st: if (bus.start) begin
        state_n  = md_unpack_st;
        eng_load = 1'b1;
      end
      // The engine is loaded on the accept edge, so the first step overlaps UNPACK.
      md_unpack_st: begin
        state_n  = md_iter_st;
        eng_step = 1'b1;
      end
      md_iter_st: begin
        eng_step = 1'b1;
        if (last_step) state_n = md_norm_st;
      end
      md_norm_st: state_n = md_pack_st;
      md_pack_st: state_n = md_idle_st;
      default:    state_n = md_idle_st;
    endcase
  end

  assign ea_s = $signed({2'b00, ea_q});
  assign eb_s = $signed({2'b00, eb_q});

  always_ff @(posedge clk) begin
    unique case (state)
      md_idle_st: if (bus.start) begin
        op_q <= bus.op;
        sa_q <= bus.operand_a[W-1];
        sb_q <= bus.operand_b[W-1];
        ea_q <= bus.operand_a[W-2:MAN_W];
        eb_q <= bus.operand_b[W-2:MAN_W];
      end
      md_unpack_st: begin
        sign_q        <= sa_q ^ sb_q;
        a_zero_q      <= (ea_q == '0);
        b_zero_q      <= (eb_q == '0);
        any_special_q <= (ea_q == '1) || (eb_q == '1);
        exp_q         <= (op_q == op_div_seq) ? (ea_s - eb_s + BIAS_E)
                                              : (ea_s + eb_s - BIAS_E);
      end
      md_norm_st: begin
        if (op_q == op_mul_seq) begin
          if (prod[2*P-1]) begin
            frac_q  <= prod[2*P-2:P];
            exp_n_q <= exp_q + EXP_ONE;
          end else begin
            frac_q  <= prod[2*P-3:P-1];
            exp_n_q <= exp_q;
          end
        end else begin
          if (quo[P]) begin
            frac_q  <= quo[P-1:1];
            exp_n_q <= exp_q;
          end else begin
            frac_q  <= quo[P-2:0];
            exp_n_q <= exp_q - EXP_ONE;
          end
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    flags_n  = '0;
    result_n = {sign_q, exp_n_q[EXP_W-1:0], frac_q};
    if (any_special_q) begin
      result_n             = W'(special_pkt(EXP_W, MAN_W, 1'b0, 1'b1));
      flags_n[FLG_INVALID] = 1'b1;
    end else if (op_q == op_div_seq && b_zero_q) begin
      if (a_zero_q) begin
        result_n             = W'(special_pkt(EXP_W, MAN_W, 1'b0, 1'b1));
        flags_n[FLG_INVALID] = 1'b1;
      end else begin
        result_n              = W'(special_pkt(EXP_W, MAN_W, sign_q, 1'b0));
        flags_n[FLG_DIV_ZERO] = 1'b1;
      end
    end else if (a_zero_q || b_zero_q) begin
      result_n          = {sign_q, {(W-1){1'b0}}};
      flags_n[FLG_ZERO] = 1'b1;
    end else if (exp_n_q >= EXP_ALL1) begin
      result_n              = W'(special_pkt(EXP_W, MAN_W, sign_q, 1'b0));
      flags_n[FLG_OVERFLOW] = 1'b1;
    end else if (exp_n_q <= EXP_ZERO) begin
      result_n               = {sign_q, {(W-1){1'b0}}};
      flags_n[FLG_UNDERFLOW] = 1'b1;
      flags_n[FLG_ZERO]      = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      done_q   <= 1'b0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      done_q <= (state == md_pack_st);
      if (state == md_pack_st) begin
        result_q <= result_n;
        flags_q  <= flags_n;
      end else if (state == md_idle_st && bus.start) begin
        flags_q <= '0;
      end
    end
  end

  assign bus.busy    = (state != md_idle_st);
  assign bus.done    = done_q;
  assign bus.result  = result_q;
  assign bus.flags   = flags_q;
  assign unused_prod = ^prod[P-2:0];

endmodule

// File: tb/tb_fpu_muldiv_seq.sv
// Directed bench for fpu_muldiv_seq: single-precision vector table plus
// re-start, mid-operation reset and half-precision back-to-back sequences.
module tb_fpu_muldiv_seq;
  import pa_fpu::*;

  logic clk = 1'b0;
  logic arst;
  always #5 clk = ~clk;

  fpu_muldiv_seq_if #(.EXP_W(8), .MAN_W(23)) bus ();
  fpu_muldiv_seq_if #(.EXP_W(5), .MAN_W(10)) hbus ();

  fpu_muldiv_seq #(.EXP_W(8), .MAN_W(23)) dut (.clk(clk), .arst(arst), .bus(bus));
  fpu_muldiv_seq #(.EXP_W(5), .MAN_W(10)) dut_h (.clk(clk), .arst(arst), .bus(hbus));

  typedef struct {
    string       name;
    e_muldiv_op  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [4:0]  flg;
    int          lat;
  } vec_t;

  vec_t vecs[13];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Called on a falling edge; returns on the falling edge of cycle 1.
  task automatic launch(input e_muldiv_op op, input logic [31:0] a, input logic [31:0] b);
    bus.op        = op;
    bus.operand_a = a;
    bus.operand_b = b;
    bus.start     = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Counts cycles since accept until done; optionally re-pulses start with
  // different operands at cycle 'repulse' to prove it is ignored.
  task automatic wait_done(input int repulse, output int lat, output int busy_cnt);
    lat      = 1;
    busy_cnt = 0;
    while (!bus.done && lat < 200) begin
      busy_cnt += int'(bus.busy);
      @(negedge clk);
      lat++;
      if (lat == repulse) begin
        bus.start     = 1'b1;
        bus.op        = op_div_seq;
        bus.operand_a = 32'h3F800000;
        bus.operand_b = 32'h40400000;
      end else begin
        bus.start = 1'b0;
      end
    end
    check("done_seen", 64'(bus.done), 64'd1);
  endtask

  task automatic h_wait(output int lat);
    lat = 1;
    while (!hbus.done && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check("h_done_seen", 64'(hbus.done), 64'd1);
  endtask

  initial begin
    int lat, bc, dcnt;

    vecs[0]  = '{"mul_3x2p5",   op_mul_seq, 32'h40400000, 32'h40200000, 32'h40F00000, 5'b00000, 27};
    vecs[1]  = '{"div_7p5/2p5", op_div_seq, 32'h40F00000, 32'h40200000, 32'h40400000, 5'b00000, 28};
    vecs[2]  = '{"div_1/3",     op_div_seq, 32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 5'b00000, 28};
    vecs[3]  = '{"div_1/0",     op_div_seq, 32'h3F800000, 32'h00000000, 32'h7F800000, 5'b01000, 28};
    vecs[4]  = '{"div_0/0",     op_div_seq, 32'h00000000, 32'h00000000, 32'h7FC00000, 5'b10000, 28};
    vecs[5]  = '{"mul_inf",     op_mul_seq, 32'h7F800000, 32'h3F800000, 32'h7FC00000, 5'b10000, 27};
    vecs[6]  = '{"mul_ovf",     op_mul_seq, 32'h71800000, 32'h71800000, 32'h7F800000, 5'b00100, 27};
    vecs[7]  = '{"mul_unf",     op_mul_seq, 32'h0D800000, 32'h0D800000, 32'h00000000, 5'b00011, 27};
    vecs[8]  = '{"mul_neg0",    op_mul_seq, 32'hC0000000, 32'h00000000, 32'h80000000, 5'b00001, 27};
    vecs[9]  = '{"div_neg",     op_div_seq, 32'hC0F00000, 32'h40200000, 32'hC0400000, 5'b00000, 28};
    vecs[10] = '{"div_0/1",     op_div_seq, 32'h00000000, 32'h3F800000, 32'h00000000, 5'b00001, 28};
    vecs[11] = '{"mul_1p5sq",   op_mul_seq, 32'h3FC00000, 32'h3FC00000, 32'h40100000, 5'b00000, 27};
    vecs[12] = '{"div_nan/0",   op_div_seq, 32'h7FC00000, 32'h00000000, 32'h7FC00000, 5'b10000, 28};

    bus.start = 1'b0;  bus.op = op_mul_seq;  bus.operand_a = '0;  bus.operand_b = '0;
    hbus.start = 1'b0; hbus.op = op_mul_seq; hbus.operand_a = '0; hbus.operand_b = '0;
    arst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_busy",   64'(bus.busy),    64'd0);
    check("rst_done",   64'(bus.done),    64'd0);
    check("rst_result", 64'(bus.result),  64'd0);
    check("rst_flags",  64'(bus.flags),   64'd0);
    check("rst_h_busy", 64'(hbus.busy),   64'd0);
    check("rst_h_res",  64'(hbus.result), 64'd0);
    arst = 1'b0;
    @(negedge clk);

    foreach (vecs[i]) begin
      launch(vecs[i].op, vecs[i].a, vecs[i].b);
      check({vecs[i].name, "_busy1"}, 64'(bus.busy), 64'd1);
      wait_done(-1, lat, bc);
      check({vecs[i].name, "_result"},  64'(bus.result), 64'(vecs[i].res));
      check({vecs[i].name, "_flags"},   64'(bus.flags),  64'(vecs[i].flg));
      check({vecs[i].name, "_latency"}, 64'(lat),        64'(vecs[i].lat));
      check({vecs[i].name, "_busycnt"}, 64'(bc),         64'(vecs[i].lat - 1));
      check({vecs[i].name, "_busy_at_done"}, 64'(bus.busy), 64'd0);
      @(negedge clk);
      check({vecs[i].name, "_done_pulse"}, 64'(bus.done), 64'd0);
      check({vecs[i].name, "_held"}, 64'(bus.result), 64'(vecs[i].res));
    end

    // Re-pulsed start mid-operation must not disturb the running multiply.
    launch(op_mul_seq, 32'h40400000, 32'h40200000);
    wait_done(5, lat, bc);
    check("repulse_result",  64'(bus.result), 64'h40F00000);
    check("repulse_flags",   64'(bus.flags),  64'd0);
    check("repulse_latency", 64'(lat),        64'd27);
    @(negedge clk);

    // Asynchronous reset at cycle 10 clears outputs immediately, no done follows.
    launch(op_div_seq, 32'h40F00000, 32'h40200000);
    for (int c = 1; c < 10; c++) @(negedge clk);
    arst = 1'b1;
    #1;
    check("arst_busy",   64'(bus.busy),   64'd0);
    check("arst_done",   64'(bus.done),   64'd0);
    check("arst_result", 64'(bus.result), 64'd0);
    check("arst_flags",  64'(bus.flags),  64'd0);
    @(negedge clk);
    arst = 1'b0;
    dcnt = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      dcnt += int'(bus.done) + int'(bus.busy);
    end
    check("arst_no_done", 64'(dcnt), 64'd0);
    launch(op_div_seq, 32'h40F00000, 32'h40200000);
    wait_done(-1, lat, bc);
    check("post_arst_result",  64'(bus.result), 64'h40400000);
    check("post_arst_latency", 64'(lat),        64'd28);
    @(negedge clk);

    // Half precision, then a second start issued in the done cycle.
    hbus.op = op_mul_seq; hbus.operand_a = 16'h4200; hbus.operand_b = 16'h4100;
    hbus.start = 1'b1;
    @(negedge clk);
    hbus.start = 1'b0;
    h_wait(lat);
    check("h_mul_result",  64'(hbus.result), 64'h4780);
    check("h_mul_flags",   64'(hbus.flags),  64'd0);
    check("h_mul_latency", 64'(lat),         64'd14);
    hbus.op = op_div_seq; hbus.operand_a = 16'h4780; hbus.operand_b = 16'h4100;
    hbus.start = 1'b1;
    @(negedge clk);
    hbus.start = 1'b0;
    check("h_b2b_accepted", 64'(hbus.busy), 64'd1);
    h_wait(lat);
    check("h_div_result",  64'(hbus.result), 64'h4200);
    check("h_div_latency", 64'(lat),         64'd15);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fpu_muldiv_seq.md
Name: fpu_muldiv_seq

Overview:
- Parametrised, iterative floating-point multiply/divide unit for Sol-1. It is the successor to the prototype FPU datapath.
- It adds restoring division, configurable exponent and mantissa widths, exception flags, and a clean start/done handshake.
- It sits behind the FPU bus-interface logic. That logic loads the operands, pulses start, and reads result and flags after done.

Parameters:
- EXP_W, 8, exponent field width. BIAS = 2^(EXP_W-1)-1 is a localparam.
- MAN_W, 23, stored fraction width. P = MAN_W+1 is the significand width including the hidden bit.
- Packet width W = 1+EXP_W+MAN_W is a localparam.

Ports:
- clk  in  1  system clock
- arst  in  1  asynchronous reset, active-high
- start  in  1  request; sampled only in IDLE
- op  in  1  0 = multiply, 1 = divide (a/b)
- operand_a  in  W  IEEE-style packet {sign, exp, frac}
- operand_b  in  W  IEEE-style packet
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse; result and flags valid from this cycle
- result  out  W  packed result; held until the next accepted start
- flags  out  5  {invalid, div_by_zero, overflow, underflow, zero}; held with result

Behaviour:
- One clock (clk); reset (arst) is asynchronous and active-high.
- Reset values: busy=0, done=0, result=0, flags=0, state=IDLE.
- arst mid-operation aborts the operation and returns to these reset values; no done pulse is produced.
- States: IDLE -> UNPACK -> ITER -> NORM -> PACK -> IDLE.
- Start handshake:
  - start high in IDLE at edge k captures operand_a, operand_b and op.
  - start while busy is ignored; operands are not re-captured.
- Iteration count N = P for multiply, P+1 for divide. The core is not pipelined.
- Latency is fixed: done is high in cycle k+N+3 (single precision: multiply 27, divide 28).
- Latency is identical for special-case operands; special cases still traverse ITER.
- done is registered. busy falls in the same cycle that done rises.
- A start in that done cycle is accepted, because the FSM is already in IDLE.
- UNPACK:
  - exp==0 means zero; denormals are flushed to zero.
  - exp==all-ones means Inf/NaN.
  - The hidden bit is 1 otherwise.
  - Sign = sa ^ sb.
  - Exponent arithmetic uses signed EXP_W+2 bits.
- Multiply:
  - Shift-add over P cycles into a 2P+1-bit accumulator; the extra bit is the carry.
  - If product bit 2P-1 is set: frac = bits[2P-2:P], exp = ea+eb-BIAS+1.
  - Otherwise: frac = bits[2P-3:P-1], exp = ea+eb-BIAS.
- Divide:
  - Restoring division over P+1 cycles produces quotient Q, value in (0.5,2).
  - If Q[P] is set: frac = Q[P-1:1], exp = ea-eb+BIAS.
  - Otherwise: frac = Q[P-2:0], exp = ea-eb+BIAS-1.
- Rounding is truncation (toward zero). No guard or sticky bits.
- Exception priority, highest first:
  1. Any Inf/NaN input -> quiet NaN {0, all-ones, 1<<(MAN_W-1)}, invalid=1.
  2. Divide with b zero and a nonzero -> signed Inf, div_by_zero=1. 0/0 -> NaN, invalid=1.
  3. Either operand zero (multiply), or a zero (divide) -> signed zero, zero=1.
  4. Biased exp >= all-ones -> signed Inf, overflow=1.
  5. Biased exp <= 0 -> signed zero, underflow=1, zero=1.
- Flags not raised by the case that applies are 0. Flags are cleared at each accepted start.

Decomposition:
- Package pa_fpu gains:
  - enum e_muldiv_op {op_mul_seq, op_div_seq}
  - enum e_muldiv_state {md_idle_st, md_unpack_st, md_iter_st, md_norm_st, md_pack_st}
  - flag bit index constants FLG_INVALID..FLG_ZERO
  - a helper function for quiet-NaN and Inf packet construction, parametrised by widths
- One sub-module, fpu_sig_iter, holds the significand engine:
  - accumulator or remainder register, quotient register, iteration counter
  - load/step/mode inputs, last_step output
- The top holds the FSM, unpack, exponent, normalisation, exceptions and packing.

Test Plan:
- mul 0x40400000 * 0x40200000 (3.0*2.5), start at cycle 0 -> done at cycle 27, result 0x40F00000, flags 0; busy high cycles 1-26.
- div 0x40F00000 / 0x40200000 -> done at cycle 28, result 0x40400000; div 0x3F800000 / 0x40400000 -> 0x3EAAAAAA (truncated).
- div 0x3F800000 / 0x00000000 -> 0x7F800000, div_by_zero=1; div 0/0 -> 0x7FC00000, invalid=1; mul 0x7F800000 * 0x3F800000 -> 0x7FC00000, invalid=1.
- mul 0x71800000 * 0x71800000 -> 0x7F800000, overflow=1; mul 0x0D800000 * 0x0D800000 -> 0x00000000, underflow=1, zero=1; mul 0xC0000000 * 0x00000000 -> 0x80000000, zero=1.
- start re-pulsed with new operands mid-operation -> ignored, first result unchanged; arst at cycle 10 -> busy, done, result and flags all 0 immediately; the next op completes normally.
- Parameter sweep EXP_W=5, MAN_W=10: mul 0x4200 * 0x4100 (3.0*2.5) -> 0x4780, done at cycle 14; back-to-back start on the done cycle is accepted.
